// File: rtl/nn_train_sequencer_if.sv
// Handshake and control bundle between the training phase sequencer and
// the NN datapath. The sequencer owns every output; start/abort come from
// the host and hold comes from the datapath.
interface nn_train_sequencer_if #(
    parameter int ROW_W  = 10,
    parameter int COL_W  = 7,
    parameter int ADDR_W = 15,
    parameter int EP_W   = 8
);
    logic              start;
    logic              abort;
    logic              hold;
    logic              busy;
    logic              done;
    logic [2:0]        phase;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic              wrom_en;
    logic              ld_we;
    logic [ROW_W-1:0]  ld_row;
    logic [COL_W-1:0]  ld_col;
    logic              mac_en;
    logic              mac_first;
    logic [ROW_W-1:0]  mac_row;
    logic [COL_W-1:0]  mac_col;
    logic              sig_en;
    logic [COL_W-1:0]  sig_idx;
    logic              upd_en;
    logic [ROW_W-1:0]  upd_row;
    logic [COL_W-1:0]  upd_col;
    logic [EP_W-1:0]   epoch;

    // Sequencer side
    modport master (
        input  start, abort, hold,
        output busy, done, phase, rom_en, rom_addr, wrom_en,
               ld_we, ld_row, ld_col, mac_en, mac_first, mac_row, mac_col,
               sig_en, sig_idx, upd_en, upd_row, upd_col, epoch
    );

    // Host / datapath side
    modport slave (
        output start, abort, hold,
        input  busy, done, phase, rom_en, rom_addr, wrom_en,
               ld_we, ld_row, ld_col, mac_en, mac_first, mac_row, mac_col,
               sig_en, sig_idx, upd_en, upd_row, upd_col, epoch
    );
endinterface

// File: rtl/nn_train_sequencer.sv
// Phase controller for the single-layer NN training datapath.
// Loads inputs/weights from ROM once, then runs forward MAC, sigmoid and
// weight-update passes for N_EPOCH epochs. A single row/col counter pair is
// shared by all phases; the per-phase index outputs are views of it.
// hold acts as a ready-low qualifier: the item on the outputs is not
// consumed while hold is high, so the strobe is gated combinationally and
// the counters simply do not advance.
module nn_train_sequencer #(
    parameter int N_FEAT  = 784,
    parameter int N_SAMP  = 40,
    parameter int N_EPOCH = 1,
    parameter int ROW_W   = 10,
    parameter int COL_W   = 7,
    parameter int ADDR_W  = 15,
    parameter int EP_W    = 8
) (
    input logic                clk,
    input logic                rst,
    nn_train_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FWD  = 3'd2,
        S_SIG  = 3'd3,
        S_UPD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_FEAT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_SAMP - 1);
    localparam logic [EP_W-1:0]  EP_LAST  = EP_W'(N_EPOCH - 1);

    state_t            state_r, state_s;
    logic [ROW_W-1:0]  row_r, row_s;
    logic [COL_W-1:0]  col_r, col_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [EP_W-1:0]   epoch_r, epoch_s;
    logic              issue_r, issue_s;   // LOAD still issuing ROM reads
    logic              ldwe_r, ldwe_s;     // ROM data valid one cycle after issue
    logic [ROW_W-1:0]  ldrow_r, ldrow_s;
    logic [COL_W-1:0]  ldcol_r, ldcol_s;
    logic              row_last_s, col_last_s;

    // Next-state and counter update: abort wins over hold, hold freezes work
    always_comb begin
        state_s    = state_r;
        row_s      = row_r;
        col_s      = col_r;
        addr_s     = addr_r;
        epoch_s    = epoch_r;
        issue_s    = issue_r;
        ldwe_s     = 1'b0;
        ldrow_s    = {ROW_W{1'b0}};
        ldcol_s    = {COL_W{1'b0}};
        row_last_s = (row_r == ROW_LAST);
        col_last_s = (col_r == COL_LAST);

        if (bus.abort && (state_r != S_IDLE)) begin
            // Dropping ldwe here suppresses the in-flight ROM write
            state_s = S_IDLE;
            row_s   = {ROW_W{1'b0}};
            col_s   = {COL_W{1'b0}};
            addr_s  = {ADDR_W{1'b0}};
            epoch_s = {EP_W{1'b0}};
            issue_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_s = S_LOAD;
                        row_s   = {ROW_W{1'b0}};
                        col_s   = {COL_W{1'b0}};
                        addr_s  = {ADDR_W{1'b0}};
                        epoch_s = {EP_W{1'b0}};
                        issue_s = 1'b1;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (issue_r) begin
                        ldwe_s  = 1'b1;
                        ldrow_s = row_r;
                        ldcol_s = col_r;
                        if (row_last_s && col_last_s) begin
                            issue_s = 1'b0;
                            row_s   = {ROW_W{1'b0}};
                            col_s   = {COL_W{1'b0}};
                            addr_s  = {ADDR_W{1'b0}};
                        end else if (row_last_s) begin
                            row_s  = {ROW_W{1'b0}};
                            col_s  = col_r + COL_W'(1);
                            addr_s = addr_r + ADDR_W'(1);
                        end else begin
                            row_s  = row_r + ROW_W'(1);
                            addr_s = addr_r + ADDR_W'(1);
                        end
                    end else begin
                        // Drain cycle: last ROM word is being written now
                        state_s = S_FWD;
                    end
                end
                S_FWD: begin
                    if (bus.hold) begin
                        state_s = S_FWD;
                    end else if (row_last_s && col_last_s) begin
                        state_s = S_SIG;
                        row_s   = {ROW_W{1'b0}};
                        col_s   = {COL_W{1'b0}};
                    end else if (row_last_s) begin
                        row_s = {ROW_W{1'b0}};
                        col_s = col_r + COL_W'(1);
                    end else begin
                        row_s = row_r + ROW_W'(1);
                    end
                end
                S_SIG: begin
                    if (bus.hold) begin
                        state_s = S_SIG;
                    end else if (col_last_s) begin
                        state_s = S_UPD;
                        col_s   = {COL_W{1'b0}};
                    end else begin
                        col_s = col_r + COL_W'(1);
                    end
                end
                S_UPD: begin
                    if (bus.hold) begin
                        state_s = S_UPD;
                    end else if (col_last_s) begin
                        col_s = {COL_W{1'b0}};
                        if (row_last_s) begin
                            row_s = {ROW_W{1'b0}};
                            if (epoch_r == EP_LAST) begin
                                state_s = S_DONE;
                            end else begin
                                epoch_s = epoch_r + EP_W'(1);
                                state_s = S_FWD;
                            end
                        end else begin
                            row_s = row_r + ROW_W'(1);
                        end
                    end else begin
                        col_s = col_r + COL_W'(1);
                    end
                end
                S_DONE: begin
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                    row_s   = {ROW_W{1'b0}};
                    col_s   = {COL_W{1'b0}};
                    addr_s  = {ADDR_W{1'b0}};
                    epoch_s = {EP_W{1'b0}};
                    issue_s = 1'b0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            row_r   <= {ROW_W{1'b0}};
            col_r   <= {COL_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            epoch_r <= {EP_W{1'b0}};
            issue_r <= 1'b0;
            ldwe_r  <= 1'b0;
            ldrow_r <= {ROW_W{1'b0}};
            ldcol_r <= {COL_W{1'b0}};
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
            col_r   <= col_s;
            addr_r  <= addr_s;
            epoch_r <= epoch_s;
            issue_r <= issue_s;
            ldwe_r  <= ldwe_s;
            ldrow_r <= ldrow_s;
            ldcol_r <= ldcol_s;
        end
    end

    // Output decode: indices are zero outside their own phase
    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.phase     = state_r;
        bus.rom_en    = 1'b0;
        bus.rom_addr  = {ADDR_W{1'b0}};
        bus.wrom_en   = 1'b0;
        bus.ld_we     = ldwe_r;
        bus.ld_row    = ldrow_r;
        bus.ld_col    = ldcol_r;
        bus.mac_en    = 1'b0;
        bus.mac_first = 1'b0;
        bus.mac_row   = {ROW_W{1'b0}};
        bus.mac_col   = {COL_W{1'b0}};
        bus.sig_en    = 1'b0;
        bus.sig_idx   = {COL_W{1'b0}};
        bus.upd_en    = 1'b0;
        bus.upd_row   = {ROW_W{1'b0}};
        bus.upd_col   = {COL_W{1'b0}};
        bus.epoch     = epoch_r;
        case (state_r)
            S_LOAD: begin
                bus.busy = 1'b1;
                if (issue_r) begin
                    bus.rom_en   = 1'b1;
                    bus.rom_addr = addr_r;
                    bus.wrom_en  = (col_r == {COL_W{1'b0}});
                end else begin
                    bus.rom_en = 1'b0;
                end
            end
            S_FWD: begin
                bus.busy      = 1'b1;
                bus.mac_en    = ~bus.hold;
                bus.mac_first = ~bus.hold && (row_r == {ROW_W{1'b0}});
                bus.mac_row   = row_r;
                bus.mac_col   = col_r;
            end
            S_SIG: begin
                bus.busy    = 1'b1;
                bus.sig_en  = ~bus.hold;
                bus.sig_idx = col_r;
            end
            S_UPD: begin
                bus.busy    = 1'b1;
                bus.upd_en  = ~bus.hold;
                bus.upd_row = row_r;
                bus.upd_col = col_r;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_nn_train_sequencer.sv
// Self-checking bench for nn_train_sequencer on a 4x3, 2-epoch configuration.
// The reference is a queue of work items built from the ordering rules;
// each post-load cycle either consumes the head item (hold low) or shows it
// frozen (hold high). LOAD timing is checked from plain index arithmetic.
module tb_nn_train_sequencer;

    localparam int NF = 4;
    localparam int NS = 3;
    localparam int NE = 2;
    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_LOAD = 3'd1;
    localparam logic [2:0] P_FWD  = 3'd2;
    localparam logic [2:0] P_SIG  = 3'd3;
    localparam logic [2:0] P_UPD  = 3'd4;
    localparam logic [2:0] P_DONE = 3'd5;

    typedef struct packed {
        logic [2:0] ph;
        int         a;
        int         b;
        int         ep;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    nn_train_sequencer_if #(.ROW_W(10), .COL_W(7), .ADDR_W(15), .EP_W(8)) bus ();

    nn_train_sequencer #(
        .N_FEAT(NF), .N_SAMP(NS), .N_EPOCH(NE),
        .ROW_W(10), .COL_W(7), .ADDR_W(15), .EP_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {bus.busy, bus.done, bus.phase, bus.rom_en, bus.rom_addr, bus.wrom_en,
                  bus.ld_we, bus.ld_row, bus.ld_col, bus.mac_en, bus.mac_first,
                  bus.mac_row, bus.mac_col, bus.sig_en, bus.sig_idx,
                  bus.upd_en, bus.upd_row, bus.upd_col}, 128'd0);
    endtask

    // mode: 0 plain run + start during FWD, 1 directed 5-cycle hold at (2,1),
    // 2 random hold everywhere + start with abort, 3 abort in UPD of epoch 0,
    // 4 abort on last LOAD issue, 5 rst during SIG
    task automatic run_check(input int mode);
        item_t q[$];
        item_t it;
        int    cyc, nheld, hcnt, upd_seen, tgt, done_cyc;
        int    n_mac, n_sig, n_upd, n_wrom;
        int    i, j;
        logic  h, ab, rs, st, on;
        logic [2:0] sexp;

        for (int e = 0; e < NE; e++) begin
            for (int c = 0; c < NS; c++)
                for (int r = 0; r < NF; r++) q.push_back('{P_FWD, r, c, e});
            for (int s = 0; s < NS; s++) q.push_back('{P_SIG, s, 0, e});
            for (int r = 0; r < NF; r++)
                for (int c = 0; c < NS; c++) q.push_back('{P_UPD, r, c, e});
        end
        q.push_back('{P_DONE, 0, 0, NE - 1});

        n_mac = 0; n_sig = 0; n_upd = 0; n_wrom = 0; done_cyc = -1;

        // cycle 0: start pulse
        tick();
        rst = 1'b0; bus.start = 1'b1; bus.hold = 1'b0;
        bus.abort = (mode == 2);
        @(negedge clk);
        chk("idle_phase", bus.phase, P_IDLE);
        chk("idle_busy", bus.busy, 1'b0);

        // LOAD: issue cycles 1..12, drain cycle 13
        for (int k = 1; k <= NF * NS + 1; k++) begin
            tick();
            bus.start = 1'b0;
            bus.hold  = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
            bus.abort = (mode == 4 && k == NF * NS);
            @(negedge clk);
            i = k - 1;
            j = k - 2;
            chk("load_phase", bus.phase, P_LOAD);
            chk("load_busy", bus.busy, 1'b1);
            chk("load_rom_en", bus.rom_en, (i < NF * NS));
            if (i < NF * NS) begin
                chk("load_rom_addr", bus.rom_addr, (i / NF) * NF + (i % NF));
                chk("load_wrom_en", bus.wrom_en, ((i / NF) == 0));
            end
            if (bus.wrom_en) n_wrom++;
            chk("load_ld_we", bus.ld_we, (j >= 0));
            if (j >= 0) begin
                chk("load_ld_row", bus.ld_row, j % NF);
                chk("load_ld_col", bus.ld_col, j / NF);
            end
            chk("load_strobes", {bus.mac_en, bus.sig_en, bus.upd_en, bus.done}, 4'd0);
            if (mode == 4 && k == NF * NS) begin
                tick();
                bus.abort = 1'b0; bus.hold = 1'b0;
                @(negedge clk);
                chk_zero("abort_load_zero");
                chk("abort_load_ld_we", bus.ld_we, 1'b0);
                return;
            end
        end
        chk("wrom_count", n_wrom, NF);

        cyc = NF * NS + 1; nheld = 0; hcnt = 0; upd_seen = 0;
        tgt = $urandom_range(0, NF * NS - 1);
        while (q.size() > 0 && cyc < 2000) begin
            it = q[0];
            cyc++;
            tick();
            h = 1'b0; ab = 1'b0; rs = 1'b0; st = 1'b0;
            case (mode)
                0: st = (it.ph == P_FWD && it.ep == 0 && it.a == 1 && it.b == 1);
                1: h  = (it.ph == P_FWD && it.ep == 0 && it.a == 2 && it.b == 1 && hcnt < 5);
                2: h  = ($urandom_range(0, 3) == 0);
                3: begin
                    ab = (it.ph == P_UPD && it.ep == 0 && upd_seen == tgt);
                    h  = ab;
                end
                5: rs = (it.ph == P_SIG && it.a == 1);
                default: h = 1'b0;
            endcase
            bus.start = st; bus.hold = h; bus.abort = ab; rst = rs;
            @(negedge clk);
            on = !h && (it.ph != P_DONE);
            chk("phase", bus.phase, it.ph);
            chk("epoch", bus.epoch, it.ep);
            chk("busy", bus.busy, (it.ph != P_DONE));
            chk("done", bus.done, (it.ph == P_DONE));
            chk("rom_ld_idle", {bus.rom_en, bus.ld_we}, 2'd0);
            sexp = (it.ph == P_FWD) ? 3'b100 : (it.ph == P_SIG) ? 3'b010 :
                   (it.ph == P_UPD) ? 3'b001 : 3'b000;
            chk("strobes", {bus.mac_en, bus.sig_en, bus.upd_en}, on ? sexp : 3'b000);
            if (it.ph == P_FWD) begin
                chk("mac_row", bus.mac_row, it.a);
                chk("mac_col", bus.mac_col, it.b);
                chk("mac_first", bus.mac_first, on && (it.a == 0));
            end
            if (it.ph == P_SIG) chk("sig_idx", bus.sig_idx, it.a);
            if (it.ph == P_UPD) begin
                chk("upd_row", bus.upd_row, it.a);
                chk("upd_col", bus.upd_col, it.b);
            end
            if (bus.mac_en) n_mac++;
            if (bus.sig_en) n_sig++;
            if (bus.upd_en) n_upd++;
            if (ab || rs) begin
                tick();
                bus.abort = 1'b0; bus.hold = 1'b0; rst = 1'b0;
                @(negedge clk);
                chk_zero(rs ? "rst_sig_zero" : "abort_upd_zero");
                if (rs) chk("rst_epoch", bus.epoch, 0);
                for (int w = 0; w < 4; w++) begin
                    tick();
                    @(negedge clk);
                    chk("post_cancel_no_done", {bus.done, bus.busy, bus.phase}, 5'd0);
                end
                return;
            end
            if (h && it.ph != P_DONE) begin
                nheld++;
                hcnt++;
            end else begin
                if (it.ph == P_UPD && it.ep == 0) upd_seen++;
                if (it.ph == P_DONE) done_cyc = cyc;
                void'(q.pop_front());
            end
        end
        chk("run_timeout", q.size(), 0);
        chk("done_cycle", done_cyc, 68 + nheld);
        chk("mac_count", n_mac, NF * NS * NE);
        chk("sig_count", n_sig, NS * NE);
        chk("upd_count", n_upd, NF * NS * NE);
        tick();
        bus.start = 1'b0; bus.hold = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        chk("after_done_idle", {bus.phase, bus.busy, bus.done}, 5'd0);
        chk("after_done_epoch", bus.epoch, NE - 1);
    endtask

    // Directed sequence of runs
    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_zero("reset_zero");
        chk("reset_epoch", bus.epoch, 0);
        run_check(0);
        run_check(1);
        run_check(2);
        run_check(2);
        run_check(3);
        run_check(0);
        run_check(4);
        run_check(2);
        run_check(5);
        run_check(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
